// File: rtl/freq_trigger_multi_if.sv
// Bundle of the control, configuration and status signals of freq_trigger_multi.
// The master side drives en/sync_clr/sel/div_factors; the slave side (the
// trigger) drives freq_trig/active_sel/cnt_out.
interface freq_trigger_multi_if #(
    parameter int CNT_W = 8,
    parameter int N_SEL = 4,
    parameter int SEL_W = 2
);
    logic                   en;
    logic                   sync_clr;
    logic [SEL_W-1:0]       sel;
    logic [N_SEL*CNT_W-1:0] div_factors;
    logic                   freq_trig;
    logic [SEL_W-1:0]       active_sel;
    logic [CNT_W-1:0]       cnt_out;

    modport master (
        output en, sync_clr, sel, div_factors,
        input  freq_trig, active_sel, cnt_out
    );

    modport slave (
        input  en, sync_clr, sel, div_factors,
        output freq_trig, active_sel, cnt_out
    );
endinterface

// File: rtl/freq_trigger_multi.sv
// Multi-rate clock-enable generator: emits a one-cycle pulse every D enabled
// cycles, where D is one of N_SEL run-time factors picked by sel. A new sel is
// only adopted at a period wrap or a synchronous restart, so the period in
// flight is never shortened or stretched.
// Optional: define FREQ_TRIG_SEL_SYNC_EN to pass sel through a two-flop
// synchroniser (adds two cycles of select latency).
module freq_trigger_multi #(
    parameter int CNT_W = 8,
    parameter int N_SEL = 4,
    parameter int SEL_W = 2
) (
    input  logic                clk_in,
    input  logic                rst_n,
    freq_trigger_multi_if.slave bus
);
    localparam logic [SEL_W:0] N_SEL_V = (SEL_W+1)'(N_SEL);

    logic [SEL_W-1:0] sel_use;
    logic [SEL_W-1:0] sel_next;
    logic [SEL_W-1:0] active_sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic             trig_q;
    logic [CNT_W-1:0] d_raw;
    logic [CNT_W-1:0] d_last;
    logic             wrap;

`ifdef FREQ_TRIG_SEL_SYNC_EN
    logic [SEL_W-1:0] sel_s1;
    logic [SEL_W-1:0] sel_s2;

    // Two-flop synchroniser for the switch-driven select.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sel_s1 <= '0;
            sel_s2 <= '0;
        end else begin
            sel_s1 <= bus.sel;
            sel_s2 <= sel_s1;
        end
    end

    assign sel_use = sel_s2;
`else
    assign sel_use = bus.sel;
`endif

    // Out-of-range indices fall back to factor 0.
    assign sel_next = ({1'b0, sel_use} >= N_SEL_V) ? '0 : sel_use;

    // Pick the active factor from the packed bus; read live every cycle.
    always_comb begin
        d_raw = '0;
        for (int i = 0; i < N_SEL; i++) begin
            if ({1'b0, active_sel_q} == (SEL_W+1)'(i))
                d_raw = bus.div_factors[i*CNT_W +: CNT_W];
        end
    end

    // D=0 behaves as D=1; >= lets a shrunken factor wrap at once instead of
    // running the counter all the way round.
    assign d_last = (d_raw == '0) ? '0 : d_raw - CNT_W'(1);
    assign wrap   = (cnt_q >= d_last);

    // Counter, pulse and active-select update: sync_clr > en > hold.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            trig_q       <= 1'b0;
            active_sel_q <= '0;
        end else if (bus.sync_clr) begin
            cnt_q        <= '0;
            trig_q       <= 1'b0;
            active_sel_q <= sel_next;
        end else if (bus.en) begin
            if (wrap) begin
                cnt_q        <= '0;
                trig_q       <= 1'b1;
                active_sel_q <= sel_next;
            end else begin
                cnt_q  <= cnt_q + CNT_W'(1);
                trig_q <= 1'b0;
            end
        end else begin
            trig_q <= 1'b0;
        end
    end

    assign bus.freq_trig  = trig_q;
    assign bus.active_sel = active_sel_q;
    assign bus.cnt_out    = cnt_q;
endmodule
